xc30xx_clb_gen: RTL and testbench



---
 rtl/xc30xx_clb_pkg.sv | 28 ++
 rtl/xc30xx_clb_cell.sv | 74 +++++++
 rtl/xc30xx_clb_gen.sv | 58 +++++
 tb/tb_xc30xx_clb_gen.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/xc30xx_clb_pkg.sv
// Shared definitions for the XC30XX-class configurable logic block.
//   K_IN_MAX / NUM_LUT_MAX : largest supported LUT width and cell count
//   lut_depth()            : number of LUT/shift-register bits for a given K_IN
//   ff_action_e / ff_action(): flip-flop update decode, priority R > SR > CE
package xc30xx_clb_pkg;

  localparam int K_IN_MAX    = 6;
  localparam int NUM_LUT_MAX = 8;

  typedef enum logic [1:0] {
    FF_RESET,  // R  : load FF_INIT (and reload shift memory)
    FF_SET,    // SR : load SR_VAL, independent of CE
    FF_LOAD,   // CE : capture LUT output
    FF_HOLD
  } ff_action_e;

  function automatic int lut_depth(input int k_in);
    return 1 << k_in;
  endfunction

  function automatic ff_action_e ff_action(input logic r, input logic sr, input logic ce);
    if (r)  return FF_RESET;
    if (sr) return FF_SET;
    if (ce) return FF_LOAD;
    return FF_HOLD;
  endfunction

endpackage

// File: rtl/xc30xx_clb_cell.sv
// One LUT/FF cell: a K_IN-input LUT (static ROM or shift register), an
// optional Q feedback into the top address bit, a D flip-flop with clock
// enable and synchronous set/reset, and the X output mux.
// Ports:
//   K   : clock, rising edge
//   R   : synchronous active-high reset (Q <= FF_INIT, shift memory <= LUT_INIT)
//   CE  : clock enable for Q and the shift memory
//   SR  : synchronous local set/reset (Q <= SR_VAL)
//   DIN : shift-in data (shift mode only)
//   I   : LUT address
//   X   : LUT output or Q, chosen by OUT_SEL
//   Q   : registered output
module xc30xx_clb_cell
  import xc30xx_clb_pkg::*;
#(
  parameter int                         K_IN     = 4,
  parameter logic [lut_depth(K_IN)-1:0] LUT_INIT = '0,
  parameter bit                         SRL_MODE = 1'b0,
  parameter bit                         FB_EN    = 1'b0,
  parameter bit                         FF_INIT  = 1'b0,
  parameter bit                         SR_VAL   = 1'b0,
  parameter bit                         OUT_SEL  = 1'b0
) (
  input  logic            K,
  input  logic            R,
  input  logic            CE,
  input  logic            SR,
  input  logic            DIN,
  input  logic [K_IN-1:0] I,
  output logic            X,
  output logic            Q
);

  localparam int D = lut_depth(K_IN);

  logic [D-1:0]    mem;
  logic [K_IN-1:0] addr;
  logic            lut_out;
  ff_action_e      action;

  // Feedback uses the pre-edge Q, so the loop through the LUT is broken by the FF.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    addr = I;
    if (FB_EN) addr[K_IN-1] = Q;
  end

  if (SRL_MODE) begin : g_srl
    // NOTE: this memory is reset on purpose: R must discard all shifted data and reload the init pattern.
    always_ff @(posedge K) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (R)       mem <= LUT_INIT;
      else if (CE) mem <= {mem[D-2:0], DIN};  // tap 0 is the newest bit
    end
  end else begin : g_rom
    wire unused_din = DIN;
    assign mem = LUT_INIT;
  end

  assign lut_out = mem[addr];
  assign action  = ff_action(R, SR, CE);

  always_ff @(posedge K) begin
    case (action)
      FF_RESET: Q <= FF_INIT;
      FF_SET:   Q <= SR_VAL;
      FF_LOAD:  Q <= lut_out;
      default:  Q <= Q;
    endcase
  end

  assign X = OUT_SEL ? Q : lut_out;

endmodule

// File: rtl/xc30xx_clb_gen.sv
// Parametrised configurable logic block: NUM_LUT cells, each a K_IN-input
// LUT that may run as a shift register, feeding a D flip-flop.
// The top level only slices the per-cell buses and fans out K, R, CE, SR.
// Ports:
//   K   : clock, rising edge
//   R   : synchronous active-high reset
//   I   : NUM_LUT*K_IN LUT address bits, cell n uses I[n*K_IN +: K_IN]
//   CE  : shared clock enable
//   SR  : shared synchronous set/reset to SR_VAL
//   DIN : per-cell shift-in data
//   X   : per-cell selected output
//   Q   : per-cell registered output
module xc30xx_clb_gen
  import xc30xx_clb_pkg::*;
#(
  parameter int                                 K_IN     = 4,
  parameter int                                 NUM_LUT  = 2,
  parameter logic [NUM_LUT*lut_depth(K_IN)-1:0] LUT_INIT = '0,
  parameter logic [NUM_LUT-1:0]                 SRL_MODE = '0,
  parameter logic [NUM_LUT-1:0]                 FB_EN    = '0,
  parameter logic [NUM_LUT-1:0]                 FF_INIT  = '0,
  parameter logic [NUM_LUT-1:0]                 SR_VAL   = '0,
  parameter logic [NUM_LUT-1:0]                 OUT_SEL  = '0
) (
  input  logic                    K,
  input  logic                    R,
  input  logic [NUM_LUT*K_IN-1:0] I,
  input  logic                    CE,
  input  logic                    SR,
  input  logic [NUM_LUT-1:0]      DIN,
  output logic [NUM_LUT-1:0]      X,
  output logic [NUM_LUT-1:0]      Q
);

  localparam int D = lut_depth(K_IN);

  for (genvar n = 0; n < NUM_LUT; n++) begin : g_cell
    xc30xx_clb_cell #(
      .K_IN     (K_IN),
      .LUT_INIT (LUT_INIT[n*D +: D]),
      .SRL_MODE (SRL_MODE[n]),
      .FB_EN    (FB_EN[n]),
      .FF_INIT  (FF_INIT[n]),
      .SR_VAL   (SR_VAL[n]),
      .OUT_SEL  (OUT_SEL[n])
    ) u_cell (
      .K   (K),
      .R   (R),
      .CE  (CE),
      .SR  (SR),
      .DIN (DIN[n]),
      .I   (I[n*K_IN +: K_IN]),
      .X   (X[n]),
      .Q   (Q[n])
    );
  end

endmodule

// File: tb/tb_xc30xx_clb_gen.sv
// Directed bench for xc30xx_clb_gen using three differently configured instances:
//   dut_a : static LUTs (AND4 in both cells), cell 1 shows Q on X, FF priority
//   dut_b : both cells in shift mode (cell 1 init 16'hA5C3)
//   dut_c : single cell with Q feedback, LUT = NOT A[3]
module tb_xc30xx_clb_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // dut_a signals
  logic       a_r, a_ce, a_sr;
  logic [7:0] a_i;
  logic [1:0] a_din, a_x, a_q;
  // dut_b signals
  logic       b_r, b_ce, b_sr;
  logic [7:0] b_i;
  logic [1:0] b_din, b_x, b_q;
  // dut_c signals
  logic       c_r, c_ce, c_sr;
  logic [3:0] c_i;
  logic [0:0] c_din, c_x, c_q;

  xc30xx_clb_gen #(
    .K_IN(4), .NUM_LUT(2), .LUT_INIT(32'h8000_8000), .SRL_MODE(2'b00), .FB_EN(2'b00),
    .FF_INIT(2'b10), .SR_VAL(2'b00), .OUT_SEL(2'b10)
  ) dut_a (
    .K(clk), .R(a_r), .I(a_i), .CE(a_ce), .SR(a_sr), .DIN(a_din), .X(a_x), .Q(a_q)
  );

  xc30xx_clb_gen #(
    .K_IN(4), .NUM_LUT(2), .LUT_INIT(32'hA5C3_0000), .SRL_MODE(2'b11), .FB_EN(2'b00),
    .FF_INIT(2'b10), .SR_VAL(2'b00), .OUT_SEL(2'b00)
  ) dut_b (
    .K(clk), .R(b_r), .I(b_i), .CE(b_ce), .SR(b_sr), .DIN(b_din), .X(b_x), .Q(b_q)
  );

  xc30xx_clb_gen #(
    .K_IN(4), .NUM_LUT(1), .LUT_INIT(16'h00FF), .SRL_MODE(1'b0), .FB_EN(1'b1),
    .FF_INIT(1'b0), .SR_VAL(1'b1), .OUT_SEL(1'b0)
  ) dut_c (
    .K(clk), .R(c_r), .I(c_i), .CE(c_ce), .SR(c_sr), .DIN(c_din), .X(c_x), .Q(c_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lut1;
    lut1 = 16'hA5C3;

    a_r = 1'b1; a_ce = 1'b0; a_sr = 1'b0; a_i = 8'h00; a_din = 2'b00;
    b_r = 1'b1; b_ce = 1'b0; b_sr = 1'b0; b_i = 8'h00; b_din = 2'b00;
    c_r = 1'b1; c_ce = 1'b0; c_sr = 1'b0; c_i = 4'hF; c_din = 1'b0;
    tick();
    a_r = 1'b0; b_r = 1'b0; c_r = 1'b0;

    // ---- dut_a: reset state and static AND4 ----
    check("a_reset_q", 16'(a_q), 16'h2);
    check("a_reset_x", 16'(a_x), 16'h2);   // X[1]=Q[1]=1, X[0]=AND4(0)=0
    a_i = 8'h0F; #1;
    check("a_and4_F", 16'(a_x[0]), 16'h1);
    a_i = 8'h0E; #1;
    check("a_and4_E", 16'(a_x[0]), 16'h0);

    // ---- dut_a: FF priority ----
    a_r = 1'b1; a_sr = 1'b1; a_ce = 1'b1; a_i = 8'hFF; tick();
    check("a_r_beats_sr_ce", 16'(a_q), 16'h2);
    a_r = 1'b0; a_sr = 1'b1; a_ce = 1'b0; tick();
    check("a_sr_without_ce", 16'(a_q), 16'h0);
    a_sr = 1'b0; a_ce = 1'b1; a_i = 8'hFF; tick();
    check("a_ce_load", 16'(a_q), 16'h3);
    check("a_x_after_load", 16'(a_x), 16'h3);
    a_ce = 1'b0; a_i = 8'h00; tick();
    check("a_ce0_hold_q", 16'(a_q), 16'h3);
    check("a_ce0_x", 16'(a_x), 16'h2);
    a_sr = 1'b1; a_ce = 1'b1; a_i = 8'hFF; tick();
    check("a_sr_beats_ce", 16'(a_q), 16'h0);
    a_sr = 1'b0; a_ce = 1'b0;

    // ---- dut_b: reset values ----
    b_i = 8'h00; #1;
    check("b_reset_q", 16'(b_q), 16'h2);
    check("b_reset_x", 16'(b_x), 16'h2);   // cell0 init 0, cell1 tap0 of A5C3 = 1

    // ---- dut_b: shift 1,0,1 into cell 0 ----
    b_ce = 1'b1;
    b_din = 2'b01; tick();
    b_din = 2'b00; tick();
    b_din = 2'b01; tick();
    b_ce = 1'b0; b_din = 2'b01;
    b_i = 8'h00; #1; check("b_tap0", 16'(b_x[0]), 16'h1);
    b_i = 8'h01; #1; check("b_tap1", 16'(b_x[0]), 16'h0);
    b_i = 8'h02; #1; check("b_tap2", 16'(b_x[0]), 16'h1);
    b_i = 8'h03; #1; check("b_tap3", 16'(b_x[0]), 16'h0);
    repeat (5) tick();
    b_i = 8'h00; #1; check("b_frozen_tap0", 16'(b_x[0]), 16'h1);
    b_i = 8'h01; #1; check("b_frozen_tap1", 16'(b_x[0]), 16'h0);
    b_i = 8'h02; #1; check("b_frozen_tap2", 16'(b_x[0]), 16'h1);

    // ---- dut_b: wrap-around at D=16 ----
    b_r = 1'b1; tick(); b_r = 1'b0;
    b_i = 8'h0F; b_ce = 1'b1;
    b_din = 2'b01; tick();
    b_din = 2'b00; repeat (14) tick();
    check("b_wrap_15_edges", 16'(b_x[0]), 16'h0);
    tick();
    check("b_wrap_16_edges", 16'(b_x[0]), 16'h1);
    tick();
    check("b_wrap_17_edges", 16'(b_x[0]), 16'h0);

    // ---- dut_b: reset mid-shift ----
    b_din = 2'b10; repeat (8) tick();
    b_i = 8'h70; #1;
    check("b_loaded_tap7", 16'(b_x[1]), 16'h1);
    b_i = 8'h80; #1;
    check("b_loaded_tap8", 16'(b_x[1]), 16'h0);
    b_r = 1'b1; b_din = 2'b11; tick();
    b_r = 1'b0; b_ce = 1'b0; b_din = 2'b00;
    check("b_midreset_q", 16'(b_q), 16'h2);
    for (int a = 0; a < 16; a++) begin
      b_i = {4'(a), 4'h0}; #1;
      check($sformatf("b_midreset_tap%0d", a), 16'(b_x[1]), 16'(lut1[a]));
    end
    b_i = 8'h00; #1;
    check("b_midreset_din_dropped", 16'(b_x[0]), 16'h0);

    // ---- dut_c: feedback toggle, I[3] forced high but replaced by Q ----
    c_i = 4'hF; #1;
    check("c_reset_q", 16'(c_q), 16'h0);
    check("c_reset_x", 16'(c_x), 16'h1);
    c_ce = 1'b1;
    tick(); check("c_toggle1", 16'(c_q), 16'h1);
    check("c_toggle1_x", 16'(c_x), 16'h0);
    tick(); check("c_toggle2", 16'(c_q), 16'h0);
    tick(); check("c_toggle3", 16'(c_q), 16'h1);
    tick(); check("c_toggle4", 16'(c_q), 16'h0);
    c_ce = 1'b0; tick(); check("c_hold", 16'(c_q), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
